// File: rtl/serial_syndrome_checker_if.sv
// rtl/serial_syndrome_checker_if.sv - serial bit input and result handshake bundle
interface serial_syndrome_checker_if #(
  parameter int N = 15,
  parameter int R = 10
);
  logic         clear;
  logic         in_bit;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] out_word;
  logic [R-1:0] out_syndrome;
  logic         out_err;
  logic         out_valid;
  logic         out_ready;

  modport master (
    output clear, in_bit, in_valid, out_ready,
    input  in_ready, out_word, out_syndrome, out_err, out_valid
  );

  modport slave (
    input  clear, in_bit, in_valid, out_ready,
    output in_ready, out_word, out_syndrome, out_err, out_valid
  );
endinterface

// File: rtl/serial_syndrome_checker.sv
// rtl/serial_syndrome_checker.sv - serial (15,5) cyclic-code syndrome computer with one-entry result buffer
module serial_syndrome_checker #(
  parameter int            N     = 15,
  parameter int            R     = 10,
  parameter logic [R-1:0]  G_LOW = 10'h137
) (
  input  logic                  clk,
  input  logic                  reset,
  serial_syndrome_checker_if.slave bus
);
  localparam int CW = $clog2(N);

  logic [CW-1:0] cnt_q;
  logic [R-1:0]  s_q;
  logic [N-2:0]  sr_q;
  logic [N-1:0]  out_word_q;
  logic [R-1:0]  out_syndrome_q;
  logic          out_err_q;
  logic          out_valid_q;

  logic          last_bit;
  logic          in_ready;
  logic          accept;
  logic [R-1:0]  s_d;

  // Only the frame-final bit can stall: it is the one that needs the buffer free.
  assign last_bit = (cnt_q == CW'(N - 1));
  assign in_ready = !(last_bit && out_valid_q && !bus.out_ready);
  assign accept   = bus.in_valid && in_ready;
  assign s_d      = {s_q[R-2:0], bus.in_bit} ^ (s_q[R-1] ? G_LOW : '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q          <= '0;
      s_q            <= '0;
      sr_q           <= '0;
      out_word_q     <= '0;
      out_syndrome_q <= '0;
      out_err_q      <= 1'b0;
      out_valid_q    <= 1'b0;
    end else begin
      if (bus.clear) begin
        cnt_q <= '0;
        s_q   <= '0;
        sr_q  <= '0;
      end else if (accept) begin
        if (last_bit) begin
          cnt_q <= '0;
          s_q   <= '0;
          sr_q  <= '0;
        end else begin
          cnt_q <= cnt_q + CW'(1);
          s_q   <= s_d;
          sr_q  <= {sr_q[N-3:0], bus.in_bit};
        end
      end

      // A load on the same edge as a consume keeps the buffer full.
      if (!bus.clear && accept && last_bit) begin
        out_word_q     <= {sr_q, bus.in_bit};
        out_syndrome_q <= s_d;
        out_err_q      <= (s_d != '0);
        out_valid_q    <= 1'b1;
      end else if (out_valid_q && bus.out_ready) begin
        out_valid_q    <= 1'b0;
      end
    end
  end

  assign bus.in_ready     = in_ready;
  assign bus.out_word     = out_word_q;
  assign bus.out_syndrome = out_syndrome_q;
  assign bus.out_err      = out_err_q;
  assign bus.out_valid    = out_valid_q;
endmodule

// File: doc/serial_syndrome_checker.md
Name: serial_syndrome_checker

Overview:
- Receive-side stage directly downstream of the (15,5) serial cyclic encoder.
- Consumes the encoder's serial codeword stream, highest-order coefficient (x^14) first, one bit per valid cycle.
- Computes the 10-bit syndrome by dividing r(x) by g(x) = 1+x+x^2+x^4+x^5+x^8+x^10, the same polynomial as the encoder.
- Holds the received word plus its syndrome in a one-entry output buffer with a valid/ready handshake, for the majority-logic decoder that follows.

Parameters:
- N, 15, codeword length in bits.
- R, 10, parity/syndrome width (N-K).
- G_LOW, 10'h137, coefficients x^0..x^9 of g(x); the x^10 term is implicit.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- clear  input  1  synchronous frame abort: bit counter and syndrome register to 0; output buffer untouched.
- in_bit  input  1  received serial bit.
- in_valid  input  1  in_bit is valid this cycle.
- in_ready  output  1  stage can accept in_bit this cycle.
- out_word  output  N  received codeword; bit 14 = first bit received (x^14).
- out_syndrome  output  R  syndrome of out_word.
- out_err  output  1  syndrome is nonzero.
- out_valid  output  1  output buffer holds a result.
- out_ready  input  1  consumer accepts the result.

Behaviour:
- Reset (asynchronous, active-high) clears:
  - bit counter, syndrome register and shift register to 0;
  - out_word = 0, out_syndrome = 0, out_err = 0, out_valid = 0.
  - in_ready = 1 once reset is released.
- Accept rule: a bit is accepted when in_valid & in_ready at the clk edge.
- Per accepted bit:
  - fb = s[9];
  - s <= {s[8:0], in_bit} ^ (fb ? G_LOW : 0);
  - shift register sr <= {sr[N-2:0], in_bit};
  - cnt <= cnt + 1.
- Frame completion: when an accepted bit has cnt == N-1, on the same edge:
  - out_word <= {sr[N-2:0], in_bit};
  - out_syndrome <= next value of s;
  - out_err <= (next s != 0);
  - out_valid <= 1;
  - cnt, s and sr all return to 0.
  - Latency: result visible the cycle after the 15th bit is accepted.
- Back-to-back frames are supported: bit 0 of the next frame may be accepted the cycle after bit 14.
- Output handshake: out_valid & out_ready at an edge clears out_valid, unless a new result loads on the same edge; the load wins and out_valid stays 1.
- Outputs hold stable while out_valid & !out_ready.
- Backpressure: in_ready = !(cnt == N-1 && out_valid && !out_ready). Only the frame-final bit is stalled; bits 0..13 are always accepted.
- States (cnt is the state): IDLE (cnt=0) -> SHIFT (1..N-1) -> back to IDLE on the final bit.
- Gaps are allowed: in_valid may drop mid-frame, and state is held.
- clear: highest priority after reset; a bit presented in the same cycle is discarded.
- in_valid low with in_ready low: no state change.
- Reset mid-frame discards the partial frame and any buffered result.

Test Plan:
- All-zero codeword, 15 zeros -> out_word=15'h0000, out_syndrome=10'h000, out_err=0, out_valid the cycle after the 15th bit.
- Generator codeword 15'h0537, sent MSB first -> out_syndrome=10'h000, out_err=0.
- Single error on zero word at x^0 (last bit=1) -> syndrome 10'h001; at x^10 -> 10'h137; at x^14 (first bit=1) -> 10'h29B; out_err=1 in each case.
- Two frames back-to-back with out_ready held low:
  - first result holds its values;
  - in_ready drops only while the second frame's 15th bit is waiting;
  - raising out_ready -> first result is consumed, second loads, out_valid stays 1.
- in_valid gaps of 1-3 cycles inside a frame, and clear asserted after 7 bits followed by a full zero frame -> results match the gap-free and no-clear references.
- Reset asserted asynchronously between clock edges mid-frame with out_valid=1 -> all outputs 0 immediately; the next full frame decodes correctly.
